// File: rtl/video_sync_decoder_if.sv
`default_nettype none
// ============================================================================
// Module   : video_sync_decoder_if
// Purpose  : Decoded-video input and captured pixel-stream bundle.
// Revision : 1.0
// ============================================================================
interface video_sync_decoder_if #(
  parameter int HMAX = 800,
  parameter int VMAX = 525
);
  localparam int c_hlen = $clog2(HMAX + 1);
  localparam int c_vlen = $clog2(VMAX + 1);

  logic              i_hsync;
  logic              i_vsync;
  logic              i_data_en;
  logic [7:0]        i_red;
  logic [7:0]        i_grn;
  logic [7:0]        i_blu;
  logic              o_rgb_valid;
  logic [7:0]        o_rgb_red;
  logic [7:0]        o_rgb_grn;
  logic [7:0]        o_rgb_blu;
  logic              o_sof;
  logic              o_eol;
  logic [c_hlen-1:0] o_x;
  logic [c_vlen-1:0] o_y;
  logic              o_locked;
  logic              o_err;
  logic [c_hlen-1:0] o_hactive;
  logic [c_hlen-1:0] o_htotal;
  logic [c_vlen-1:0] o_vactive;
  logic [c_vlen-1:0] o_vtotal;

  modport master (
    output i_hsync, i_vsync, i_data_en, i_red, i_grn, i_blu,
    input  o_rgb_valid, o_rgb_red, o_rgb_grn, o_rgb_blu, o_sof, o_eol, o_x, o_y,
    input  o_locked, o_err, o_hactive, o_htotal, o_vactive, o_vtotal
  );

  modport slave (
    input  i_hsync, i_vsync, i_data_en, i_red, i_grn, i_blu,
    output o_rgb_valid, o_rgb_red, o_rgb_grn, o_rgb_blu, o_sof, o_eol, o_x, o_y,
    output o_locked, o_err, o_hactive, o_htotal, o_vactive, o_vtotal
  );
endinterface
`default_nettype wire

// File: rtl/video_sync_decoder.sv
`default_nettype none
// ============================================================================
// Module   : video_sync_decoder
// Purpose  : Recovers frame timing from decoded video, locks, emits x/y stream.
// Revision : 1.0
// ============================================================================
module video_sync_decoder #(
  parameter int HMAX        = 800,
  parameter int VMAX        = 525,
  parameter int LOCK_FRAMES = 2
) (
  input  wire logic           clk,
  input  wire logic           rstn,
  video_sync_decoder_if.slave vif
);
  localparam int c_hlen = $clog2(HMAX + 1);
  localparam int c_vlen = $clog2(VMAX + 1);
  localparam int c_llen = $clog2(2 * VMAX + 1);
  localparam logic [c_llen-1:0] c_tmo  = c_llen'(2 * VMAX);
  localparam logic [3:0]        c_lock = 4'(LOCK_FRAMES);

  typedef enum logic [1:0] {
    S_SEARCH  = 2'd0,
    S_MEASURE = 2'd1,
    S_LOCKED  = 2'd2
  } state_t;

  logic              r_s1_hs, r_s1_vs, r_s1_de, r_d_hs, r_d_vs, r_d_de;
  logic [7:0]        r_s1_red, r_s1_grn, r_s1_blu;
  logic              w_de_rise, w_de_fall, w_hs_rise, w_vs_rise;
  logic [c_hlen-1:0] r_hcyc, r_x, w_x_cur, r_ref_hactive, r_ref_htotal;
  logic [c_vlen-1:0] r_act;
  logic [c_llen-1:0] r_lines;
  logic              r_frame_ok, w_hact_bad, w_htot_bad;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      {r_s1_hs, r_s1_vs, r_s1_de, r_d_hs, r_d_vs, r_d_de} <= '0;
      {r_s1_red, r_s1_grn, r_s1_blu} <= '0;
    end else begin
      r_s1_hs  <= vif.i_hsync;
      r_s1_vs  <= vif.i_vsync;
      r_s1_de  <= vif.i_data_en;
      r_s1_red <= vif.i_red;
      r_s1_grn <= vif.i_grn;
      r_s1_blu <= vif.i_blu;
      r_d_hs   <= r_s1_hs;
      r_d_vs   <= r_s1_vs;
      r_d_de   <= r_s1_de;
    end
  end

  assign w_de_rise = r_s1_de & ~r_d_de;
  assign w_de_fall = ~r_s1_de & r_d_de;
  assign w_hs_rise = r_s1_hs & ~r_d_hs;
  assign w_vs_rise = r_s1_vs & ~r_d_vs;
  assign w_x_cur   = w_de_rise ? '0 : r_x;

  // The first line's htotal spans vertical blanking, so line 1 is the reference.
  assign w_hact_bad = w_de_fall && (r_act != '0) && (r_x != r_ref_hactive);
  assign w_htot_bad = w_de_rise && (r_act > c_vlen'(1)) && (r_hcyc != r_ref_htotal);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_hcyc        <= '0;
      r_x           <= '0;
      r_act         <= '0;
      r_lines       <= '0;
      r_ref_hactive <= '0;
      r_ref_htotal  <= '0;
      r_frame_ok    <= 1'b0;
    end else begin
      if (w_de_rise)            r_hcyc <= c_hlen'(1);
      else if (r_hcyc != '1)    r_hcyc <= r_hcyc + 1'b1;
      if (r_s1_de)              r_x <= (w_x_cur == '1) ? w_x_cur : w_x_cur + 1'b1;
      if (w_de_rise && r_act == c_vlen'(1)) r_ref_htotal  <= r_hcyc;
      if (w_de_fall && r_act == '0)         r_ref_hactive <= r_x;
      if (w_vs_rise) begin
        r_lines <= '0;
        r_act   <= '0;
      end else begin
        if (w_hs_rise && r_lines != '1) r_lines <= r_lines + 1'b1;
        if (w_de_fall && r_act != '1)   r_act   <= r_act + 1'b1;
      end
      if (w_vs_rise)                      r_frame_ok <= 1'b1;
      else if (w_hact_bad || w_htot_bad)  r_frame_ok <= 1'b0;
    end
  end

  state_t            r_state;
  logic [3:0]        r_match, w_match_next;
  logic [c_hlen-1:0] r_cand_hactive, r_cand_htotal, r_hactive_o, r_htotal_o;
  logic [c_vlen-1:0] r_cand_act, r_vactive_o, r_vtotal_o;
  logic [c_llen-1:0] r_cand_lines;
  logic              r_locked, r_err, w_cand_valid, w_cand_eq, w_lock_lost;

  assign w_cand_valid = r_frame_ok && (r_act != '0) && (r_ref_hactive != '0);
  assign w_cand_eq    = (r_ref_hactive == r_cand_hactive) && (r_ref_htotal == r_cand_htotal)
                     && (r_act == r_cand_act) && (r_lines == r_cand_lines);
  assign w_match_next = w_cand_eq ? r_match + 4'd1 : 4'd1;
  assign w_lock_lost  = (w_de_fall && (r_x != r_hactive_o)) || (w_vs_rise && !w_cand_eq)
                     || (r_lines >= c_tmo);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state        <= S_SEARCH;
      r_match        <= '0;
      r_cand_hactive <= '0;
      r_cand_htotal  <= '0;
      r_cand_act     <= '0;
      r_cand_lines   <= '0;
      r_hactive_o    <= '0;
      r_htotal_o     <= '0;
      r_vactive_o    <= '0;
      r_vtotal_o     <= '0;
      r_locked       <= 1'b0;
      r_err          <= 1'b0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        S_SEARCH: begin
          if (w_vs_rise) begin
            r_state <= S_MEASURE;
            r_match <= '0;
          end
        end
        S_MEASURE: begin
          if (w_vs_rise) begin
            if (w_cand_valid) begin
              r_match        <= w_match_next;
              r_cand_hactive <= r_ref_hactive;
              r_cand_htotal  <= r_ref_htotal;
              r_cand_act     <= r_act;
              r_cand_lines   <= r_lines;
              if (w_match_next == c_lock) begin
                r_state     <= S_LOCKED;
                r_locked    <= 1'b1;
                r_hactive_o <= r_ref_hactive;
                r_htotal_o  <= r_ref_htotal;
                r_vactive_o <= r_act;
                r_vtotal_o  <= r_lines[c_vlen-1:0];
              end
            end else begin
              r_match <= '0;
            end
          end
        end
        S_LOCKED: begin
          if (w_lock_lost) begin
            r_state  <= S_SEARCH;
            r_match  <= '0;
            r_locked <= 1'b0;
            r_err    <= 1'b1;
          end
        end
        default: r_state <= S_SEARCH;
      endcase
    end
  end

  logic              r_valid, r_sof, r_eol;
  logic [7:0]        r_red, r_grn, r_blu;
  logic [c_hlen-1:0] r_ox;
  logic [c_vlen-1:0] r_oy;

  // Pixel data and coordinates hold their last values whenever unlocked.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      {r_valid, r_sof, r_eol} <= '0;
      {r_red, r_grn, r_blu}   <= '0;
      r_ox                    <= '0;
      r_oy                    <= '0;
    end else if (r_locked) begin
      r_valid <= r_s1_de;
      r_sof   <= r_s1_de && (w_x_cur == '0) && (r_act == '0);
      r_eol   <= r_s1_de && (w_x_cur == r_hactive_o - 1'b1);
      if (r_s1_de) begin
        r_red <= r_s1_red;
        r_grn <= r_s1_grn;
        r_blu <= r_s1_blu;
        r_ox  <= w_x_cur;
        r_oy  <= r_act;
      end
    end else begin
      {r_valid, r_sof, r_eol} <= '0;
    end
  end

  assign vif.o_rgb_valid = r_valid;
  assign vif.o_rgb_red   = r_red;
  assign vif.o_rgb_grn   = r_grn;
  assign vif.o_rgb_blu   = r_blu;
  assign vif.o_sof       = r_sof;
  assign vif.o_eol       = r_eol;
  assign vif.o_x         = r_ox;
  assign vif.o_y         = r_oy;
  assign vif.o_locked    = r_locked;
  assign vif.o_err       = r_err;
  assign vif.o_hactive   = r_hactive_o;
  assign vif.o_htotal    = r_htotal_o;
  assign vif.o_vactive   = r_vactive_o;
  assign vif.o_vtotal    = r_vtotal_o;
endmodule
`default_nettype wire

// File: doc/video_sync_decoder.md
Name: video_sync_decoder

Overview:
Sink-side counterpart of the HDMI transmit controller. Takes the post-TMDS-decode video signals (hsync, vsync, data enable, 8-bit RGB), recovers the frame timing, measures the active and total geometry, and locks once the timing is stable. When locked, it emits a pixel stream with x/y coordinates and start-of-frame and end-of-line markers for downstream capture logic.

Parameters:
HMAX, 800, upper bound of horizontal total; sets horizontal counter width HLen = $clog2(HMAX+1)
VMAX, 525, upper bound of vertical total; sets vertical counter width VLen = $clog2(VMAX+1)
LOCK_FRAMES, 2, consecutive identical complete frames required to lock (1..15)

Ports:
clk  in  1  pixel clock
rstn  in  1  synchronous active-low reset
i_hsync  in  1  horizontal sync, active-high
i_vsync  in  1  vertical sync, active-high
i_data_en  in  1  active-video enable
i_red / i_grn / i_blu  in  8 each  pixel data, valid when i_data_en=1
o_rgb_valid  out  1  output pixel valid
o_rgb_red / o_rgb_grn / o_rgb_blu  out  8 each  output pixel
o_sof  out  1  high with the first pixel of a frame (x=0, y=0)
o_eol  out  1  high with the last pixel of each line
o_x  out  HLen  pixel column
o_y  out  VLen  line row
o_locked  out  1  timing locked
o_err  out  1  one-cycle pulse on loss of lock
o_hactive / o_htotal  out  HLen  locked horizontal geometry
o_vactive / o_vtotal  out  VLen  locked vertical geometry

Behaviour:
- Clock clk; reset rstn, synchronous, active-low. Reset is dominant over every other update in the same cycle.
- Reset values: all outputs 0; FSM in SEARCH; all counters and match count 0.
- Stage 1 registers every input. Edge detection compares stage 1 against its own delayed copy:
  - DE rise and DE fall;
  - hsync rise, which counts one line;
  - vsync rise, which marks a frame boundary.
- Stage 2 drives the outputs. Total latency from input pins to o_rgb_* is 2 cycles.
- Horizontal counters:
  - hcyc counts clk between DE rises. On a DE rise, the previous value becomes line_htotal and hcyc reloads to 1.
  - x counts DE-high cycles and clears on the DE rise. At the DE fall, x becomes line_hactive.
- Vertical counters:
  - lines counts hsync rises since the last vsync rise.
  - act counts DE falls since the last vsync rise.
  - Both clear on a vsync rise.
- All counters saturate at all-ones and never wrap.
- frame_ok flag:
  - Set on a vsync rise.
  - Cleared if any line's line_hactive or line_htotal differs from the first line of that frame, ignoring the htotal of the first line after vsync.
- FSM, SEARCH → MEASURE → LOCKED:
  - SEARCH: on a vsync rise, go to MEASURE with match count 0.
  - MEASURE: on each vsync rise, candidate = (first-line hactive, htotal, act, lines).
    - If frame_ok, act ≠ 0 and hactive ≠ 0, compare the candidate with the stored one. If equal, match count increments; otherwise match count becomes 1. Store the candidate.
    - Otherwise match count becomes 0.
    - When match count reaches LOCK_FRAMES, go to LOCKED: o_locked=1 and the o_h*/o_v* outputs are loaded. Both take effect in the cycle after the vsync-rise edge detection.
  - LOCKED exits to SEARCH, with o_locked=0 and a one-cycle o_err pulse, on any of:
    - a line whose line_hactive ≠ o_hactive;
    - a frame whose measurement ≠ the locked values;
    - lines reaching 2*VMAX without a vsync rise.
  - If several exit conditions occur in the same cycle, only one o_err pulse is produced.
- Output stream:
  - o_rgb_valid = locked && stage-1 DE.
  - o_sof = valid && x==0 && y==0.
  - o_eol = valid && x==o_hactive-1.
  - o_y = act within the frame.
  - When not locked: valid, sof and eol are 0; RGB, x and y hold their last values.
- A line shorter than o_hactive causes loss of lock, and no o_eol is produced for that line.

Test Plan:
All scenarios use params HMAX=15, VMAX=8, LOCK_FRAMES=2. Stimulus timing is 8-pixel active width, htotal 15; 4 active lines, vtotal 8; sync positions follow the transmitter.
1. Reset: assert rstn=0 for 3 cycles with random inputs → all outputs 0, o_locked=0.
2. Lock: drive 4 clean frames → o_locked rises exactly 1 cycle after the stage-1 vsync-rise edge that ends the 2nd complete frame; o_hactive=8, o_htotal=15, o_vactive=4, o_vtotal=8; no o_rgb_valid before lock.
3. Stream after lock: pixel value = pixel index 0..31 → 32 valid beats, each 2 cycles after its input, in order. o_sof once on pixel 0. o_eol on x=7 for y=0..3. o_x cycles 0..7.
4. Short line: after lock, one line has DE high for 7 cycles → o_err pulses once, o_locked=0, no o_eol for that line; relock after 2 further clean complete frames.
5. Timeout: after lock, stop vsync while hsync continues → unlock with o_err at the 16th line (2*VMAX).
6. Reset mid-frame while locked (rstn=0 at x=3, y=2) → all outputs 0 next cycle; lock is regained only after the full SEARCH → MEASURE sequence.
